// File: rtl/sevseg_pkg.sv
// -----------------------------------------------------------------------------
// sevseg_pkg
// Shared types and glyph tables for the seven-segment scan driver.
//   seg_t        : 7-bit segment vector {g,f,e,d,c,b,a}, active-low
//   scan_state_e : scan FSM states (GUARD, DRIVE)
//   SEG_OFF      : all segments dark
//   HEX_GLYPH    : hex digits 0-F
//   PFD_GLYPH    : status glyphs blank / P / F / D
// -----------------------------------------------------------------------------
package sevseg_pkg;

    typedef logic [6:0] seg_t;

    typedef enum logic {
        GUARD = 1'b0,
        DRIVE = 1'b1
    } scan_state_e;

    localparam seg_t SEG_OFF = 7'h7F;

    localparam seg_t HEX_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam seg_t PFD_GLYPH [4] = '{
        7'h7F,  // blank
        7'h0C,  // P
        7'h0E,  // F
        7'h21   // D
    };

endpackage

// File: rtl/sevseg_glyph_rom.sv
// -----------------------------------------------------------------------------
// sevseg_glyph_rom
// Combinational glyph lookup for a single digit.
// Ports:
//   nibble : 4-bit digit value
//   mode   : 0 = hex glyph, 1 = status glyph from nibble[1:0]
//   seg    : active-low segment pattern {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module sevseg_glyph_rom
    import sevseg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       mode,
    output seg_t       seg
);

    always_comb begin
        seg = SEG_OFF;
        if (mode) begin
            seg = PFD_GLYPH[nibble[1:0]];
        end else begin
            seg = HEX_GLYPH[nibble];
        end
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_driver
// Time-multiplexed driver for an N-digit common-anode seven-segment display.
// Each digit is held REFRESH_DIV cycles; the first of those cycles is an
// anode-off guard cycle so the previous digit's segments never ghost onto
// the next anode.
//
// Optional build macro: SEVSEG_LZB_EN enables leading-zero blanking.
//
// Ports:
//   i_Clk      : system clock, rising edge
//   i_Rst      : asynchronous active-high reset
//   i_Value    : nibble per digit, digit k = bits [4k+3:4k], digit 0 rightmost
//   i_Mode     : per digit, 0 = hex glyph, 1 = status glyph
//   i_Load     : capture i_Value / i_Mode into the shadow register
//   i_Blank    : force all anodes off (scanning continues)
//   o_Seg      : active-low segments {g,f,e,d,c,b,a}
//   o_Anode    : one-hot-low digit enable
//   o_DigitIdx : index of the digit currently driven
//
// state | meaning
// ------+-------------------------------------------------------------
// GUARD | first cycle of a digit period, all anodes off
// DRIVE | remaining cycles of the period, anode of o_DigitIdx on
// -----------------------------------------------------------------------------
module seven_seg_scan_driver
    import sevseg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
)(
    input  logic                    i_Clk,
    input  logic                    i_Rst,
    input  logic [4*NUM_DIGITS-1:0] i_Value,
    input  logic [NUM_DIGITS-1:0]   i_Mode,
    input  logic                    i_Load,
    input  logic                    i_Blank,
    output logic [6:0]              o_Seg,
    output logic [NUM_DIGITS-1:0]   o_Anode,
    output logic [IDX_W-1:0]        o_DigitIdx
);

    localparam int               PRE_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    scan_state_e               state;
    scan_state_e               state_nxt;
    logic [PRE_W-1:0]          prescaler;
    logic [PRE_W-1:0]          prescaler_nxt;
    logic                      tick;
    logic [IDX_W-1:0]          idx;
    logic [IDX_W-1:0]          idx_nxt;
    logic [4*NUM_DIGITS-1:0]   shadow_val;
    logic [4*NUM_DIGITS-1:0]   shadow_val_nxt;
    logic [NUM_DIGITS-1:0]     shadow_mode;
    logic [NUM_DIGITS-1:0]     shadow_mode_nxt;
    logic [3:0]                sel_nibble;
    logic                      sel_mode;
    seg_t                      rom_seg;
    seg_t                      seg_nxt;
    logic [NUM_DIGITS-1:0]     anode_nxt;

    // Prescaler: the wrap cycle is the tick that advances the digit.
    always_comb begin
        tick          = (prescaler == PRE_LAST);
        prescaler_nxt = tick ? '0 : prescaler + 1'b1;
    end

    // Next-state logic. The tick always lands the FSM in GUARD; with
    // REFRESH_DIV >= 2 a guard cycle never coincides with a tick.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            GUARD:   state_nxt = DRIVE;
            DRIVE:   state_nxt = DRIVE;
            default: state_nxt = GUARD;
        endcase
        if (tick) begin
            state_nxt = GUARD;
            idx_nxt   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state <= GUARD;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs are registered but computed from the post-edge values of the
    // shadow and index, so a load (or a load coinciding with a tick) is
    // visible on o_Seg right after the edge that captured it.
    always_comb begin
        shadow_val_nxt  = i_Load ? i_Value : shadow_val;
        shadow_mode_nxt = i_Load ? i_Mode  : shadow_mode;
        sel_nibble      = shadow_val_nxt[{idx_nxt, 2'b00} +: 4];
        sel_mode        = shadow_mode_nxt[idx_nxt];
    end

    sevseg_glyph_rom u_glyph_rom (
        .nibble (sel_nibble),
        .mode   (sel_mode),
        .seg    (rom_seg)
    );

`ifdef SEVSEG_LZB_EN
    // A digit is "empty" when it would show nothing significant: hex zero
    // or status glyph 0. Hex zeros above the highest non-empty digit go dark.
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  higher_empty;

    always_comb begin
        lz_mask      = '0;
        higher_empty = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if (higher_empty && !shadow_mode_nxt[k] &&
                (shadow_val_nxt[4*k +: 4] == 4'h0)) begin
                lz_mask[k] = 1'b1;
            end
            higher_empty = higher_empty &&
                (shadow_mode_nxt[k] ? (shadow_val_nxt[4*k +: 2] == 2'b00)
                                    : (shadow_val_nxt[4*k +: 4] == 4'h0));
        end
    end

    assign seg_nxt = lz_mask[idx_nxt] ? SEG_OFF : rom_seg;
`else
    assign seg_nxt = rom_seg;
`endif

    always_comb begin
        anode_nxt = '1;
        if ((state_nxt == DRIVE) && !i_Blank) begin
            anode_nxt[idx_nxt] = 1'b0;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            prescaler   <= '0;
            idx         <= '0;
            shadow_val  <= '0;
            shadow_mode <= '0;
            o_Seg       <= SEG_OFF;
            o_Anode     <= '1;
        end else begin
            prescaler   <= prescaler_nxt;
            idx         <= idx_nxt;
            shadow_val  <= shadow_val_nxt;
            shadow_mode <= shadow_mode_nxt;
            o_Seg       <= seg_nxt;
            o_Anode     <= anode_nxt;
        end
    end

    assign o_DigitIdx = idx;

endmodule
